branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data/PC width; CNT_W, default 16, statistics counter width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 i_clk  in  1  rising-edge clock.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 i_ex_valid  in  1  EX stage holds a valid instruction.
REQ-006 i_ex_is_branch  in  1  EX instruction is a conditional branch.
REQ-007 i_ex_funct3  in  3  branch funct3 of EX instruction.
REQ-008 i_ex_pc  in  XLEN  PC of EX instruction.
REQ-009 i_br_less  in  1  comparator result, rs1 < rs2 in the mode selected by o_br_un.
REQ-010 i_br_equal  in  1  comparator result, rs1 == rs2.
REQ-011 i_stall  in  1  pipeline freeze; EX contents repeat next cycle.
REQ-012 o_br_un  out  1  comparator mode; 1 = unsigned, 0 = signed; combinational from i_ex_funct3.
REQ-013 o_redirect  out  1  one-cycle fetch redirect request.
REQ-014 o_redirect_pc  out  XLEN  redirect target, i_ex_pc + 4 of the mispredicted branch.
REQ-015 o_flush  out  1  kill IF/ID and ID/EX contents this cycle.
REQ-016 o_branch_cnt  out  CNT_W  resolved-branch count.
REQ-017 o_mispredict_cnt  out  CNT_W  mispredicted-branch count.

Function
REQ-018 o_br_un SHALL be 1 for funct3 110 (BLTU) and 111 (BGEU), and 0 otherwise.
REQ-019 Taken SHALL be: 000 equal; 001 !equal; 100/110 less; 101/111 !less.
REQ-020 Funct3 010/011 SHALL be treated as a non-branch: not counted, no redirect.
REQ-021 The fetch predictor is always-taken, so a resolved branch SHALL be a mispredict exactly when taken = 0.
REQ-022 A resolution event SHALL occur when the FSM is in IDLE, i_ex_valid = 1, i_ex_is_branch = 1, funct3 is legal and i_stall = 0.
REQ-023 The FSM SHALL have states IDLE and FLUSH.
REQ-024 IDLE -> FLUSH SHALL occur on a resolution event with a mispredict; otherwise the FSM SHALL stay in IDLE.
REQ-025 FLUSH -> IDLE SHALL occur on the next cycle with i_stall = 0; while i_stall = 1 the FSM SHALL stay in FLUSH with all outputs held.
REQ-026 o_redirect, o_flush and o_redirect_pc SHALL be registered and asserted only in FLUSH, one cycle after the resolving EX cycle.
REQ-027 In FLUSH, EX inputs SHALL be ignored (wrong-path instruction): no resolution, no counting.
REQ-028 o_redirect_pc SHALL equal i_ex_pc + 4 modulo 2^XLEN, with wrap at all-ones PC.
REQ-029 o_redirect_pc SHALL hold its last value outside FLUSH.
REQ-030 o_branch_cnt SHALL increment by 1 on every resolution event.
REQ-031 o_mispredict_cnt SHALL increment by 1 on every mispredicting resolution event, updating in the same cycle as o_branch_cnt.
REQ-032 Both counters SHALL saturate at 2^CNT_W - 1.
REQ-033 A stalled EX branch SHALL resolve exactly once, on the first cycle with i_stall = 0.

Reset
REQ-034 On i_reset = 1 at a clock edge: state IDLE, o_redirect 0, o_flush 0, o_redirect_pc 0, both counters 0.
REQ-035 Reset SHALL take priority over a simultaneous resolution event and over i_stall.
REQ-036 Reset asserted in FLUSH SHALL abort the flush, with outputs 0 on the following cycle.

Structure
REQ-037 A shared package riscv_br_pkg SHALL hold the funct3 constants (BEQ..BGEU) and the state enum {IDLE, FLUSH}.
REQ-038 The combinational taken/br_un decode SHALL be one sub-module, br_decide; the FSM, PC adder and counters SHALL be in the top.

Verification
REQ-039 BEQ, pc = 0x100, equal = 1 -> no redirect; branch_cnt = 1, mispredict_cnt = 0.
REQ-040 BNE, pc = 0x200, equal = 1 -> next cycle o_redirect = o_flush = 1 and redirect_pc = 0x204; mispredict_cnt = 1; the EX branch in the flush cycle is not counted.
REQ-041 BLTU, rs1 = 0xFFFFFFFF vs 1 (less = 0) -> o_br_un = 1, not taken, redirect to pc + 4; BLT on the same operands (less = 1) -> o_br_un = 0, taken, no redirect.
REQ-042 Mispredict with i_stall = 1 for 3 cycles in FLUSH -> o_redirect/o_flush held 4 cycles total; counters change once.
REQ-043 Preload counters near max, issue 2 mispredicts -> both counters stick at 0xFFFF; pc = 0xFFFFFFFC mispredict -> redirect_pc = 0x00000000.
REQ-044 Reset asserted in the FLUSH cycle -> next cycle o_redirect = 0, o_flush = 0, counters = 0.

Source files
------------

// File: rtl/riscv_br_pkg.sv
// Shared branch definitions: funct3 encodings and resolve FSM states.
package riscv_br_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic {
        IDLE,
        FLUSH
    } br_state_e;

endpackage

// File: rtl/br_decide.sv
// Combinational branch decision: taken, comparator mode and funct3 legality.
module br_decide
    import riscv_br_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_less,
    input  logic       i_equal,
    output logic       o_taken,
    output logic       o_br_un,
    output logic       o_legal
);

    // Decode funct3 into taken/legal; 010/011 are not branches.
    always_comb begin
        o_taken = 1'b0;
        o_legal = 1'b1;
        case (i_funct3)
            BEQ:          o_taken = i_equal;
            BNE:          o_taken = !i_equal;
            BLT, BLTU:    o_taken = i_less;
            BGE, BGEU:    o_taken = !i_less;
            default:      o_legal = 1'b0;
        endcase
    end

    // Unsigned compare only for BLTU/BGEU.
    always_comb begin
        o_br_un = (i_funct3 == BLTU) || (i_funct3 == BGEU);
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches against an always-taken prediction, issues a
// registered one-cycle redirect/flush on mispredict, and keeps statistics.
module branch_resolve_unit
    import riscv_br_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_branch,
    input  logic [2:0]       i_ex_funct3,
    input  logic [XLEN-1:0]  i_ex_pc,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    input  logic             i_stall,
    output logic             o_br_un,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [XLEN-1:0]  PcStep = XLEN'(4);

    br_state_e        r_state;
    br_state_e        w_state_d;
    logic             r_redirect;
    logic             r_flush;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic             w_taken;
    logic             w_legal;
    logic             w_resolve;
    logic             w_mispredict;
    logic [XLEN-1:0]  w_pc_next;

    br_decide u_br_decide (
        .i_funct3 (i_ex_funct3),
        .i_less   (i_br_less),
        .i_equal  (i_br_equal),
        .o_taken  (w_taken),
        .o_br_un  (o_br_un),
        .o_legal  (w_legal)
    );

    // Resolution only from IDLE; in FLUSH the EX slot holds a wrong-path op.
    always_comb begin
        w_resolve    = (r_state == IDLE) && i_ex_valid && i_ex_is_branch && w_legal && !i_stall;
        w_mispredict = w_resolve && !w_taken;
        w_pc_next    = i_ex_pc + PcStep;
    end

    // Next-state: enter FLUSH on mispredict, leave on the first unstalled cycle.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_mispredict) w_state_d = FLUSH;
            FLUSH:   if (!i_stall) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // State and registered redirect/flush outputs, high exactly while in FLUSH.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_redirect <= (w_state_d == FLUSH);
            r_flush    <= (w_state_d == FLUSH);
        end
    end

    // Redirect target captured at the mispredict; held otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_redirect_pc <= '0;
        end else if (w_mispredict) begin
            r_redirect_pc <= w_pc_next;
        end
    end

    // Saturating statistics counters, both updated on the resolving cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_resolve && (r_branch_cnt != CntMax)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_mispredict && (r_mispredict_cnt != CntMax)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
        end
    end

    assign o_redirect       = r_redirect;
    assign o_flush          = r_flush;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;

endmodule
